ai_score_pack: RTL and testbench
================================

Name: ai_score_pack

Overview:
- Upstream stage of the decision comparator in the speech-command path.
- Receives a stream of per-template distances tagged with class index and keeps the minimum distance per class and overall.
- On end of frame, converts each class minimum into an 8-bit similarity score.
- Packs the 8 scores into two 32-bit words and pulses score_rdy; also presents the frame's global minimum distance (24'hFFFFFF means no template seen).

Parameters:
- NCLASS, 8, number of classes; fixed by the 2x32-bit packing, no other value supported.
- DIST_W, 24, distance width.
- SHIFT, 8, right shift applied to a distance before score conversion.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- init  in  1  clear all state, abort any frame in progress
- dist_valid  in  1  distance sample valid
- dist_class  in  3  class index of the sample
- dist_value  in  24  distance, smaller = better match
- frame_done  in  1  end-of-frame strobe
- busy  out  1  high in CONVERT and PUBLISH
- drop_err  out  1  sticky: a sample or frame_done was dropped
- min  out  24  global minimum distance of last published frame
- reg1  out  32  scores of classes 0..3; class0 in [31:24], class3 in [7:0]
- reg2  out  32  scores of classes 4..7; class4 in [31:24], class7 in [7:0]
- score_rdy  out  1  one-cycle pulse: reg1/reg2/min updated

Behaviour:
- Reset (rst) and init, with init taking priority over every other input:
  - state ACCUM; all per-class minima and the running global minimum set to 24'hFFFFFF.
  - reg1 = reg2 = 0, min = 24'hFFFFFF, score_rdy = 0, busy = 0, drop_err = 0, conversion counter = 0.
- State ACCUM:
  - dist_valid: cls_min[dist_class] is replaced when dist_value < cls_min (strict; ties keep the old value). The global minimum updates the same way.
  - frame_done: go to CONVERT with counter = 0. A dist_valid in the same cycle is included in the frame.
- State CONVERT, 8 cycles, counter 0..7, one class per cycle:
  - q = cls_min[counter] >> SHIFT.
  - score = (q > 255) ? 0 : 255 - q[7:0].
  - score goes into a staging register. At counter 7, go to PUBLISH.
- State PUBLISH, 1 cycle:
  - reg1, reg2 and min load from staging and the running minimum; score_rdy = 1.
  - per-class minima and running minimum reset to 24'hFFFFFF; return to ACCUM.
  - Outputs hold until the next PUBLISH, init or rst.
- Latency: frame_done sampled at the end of cycle 0 -> CONVERT in cycles 1..8 -> score_rdy high in cycle 9, together with the new reg1/reg2/min.
- Drops: a dist_valid or frame_done while busy = 1 is discarded and sets drop_err. drop_err clears only on rst or init.
- Empty frame (frame_done with no samples): all scores 0, min = 24'hFFFFFF; the downstream comparator then forces reject.
- init during CONVERT/PUBLISH: abort and apply the reset values; no score_rdy is produced.
- score_rdy is never high on two consecutive cycles. The minimum spacing is 10 cycles.

Decomposition:
- Shared package holds:
  - constants NCLASS = 8, DIST_W = 24, SCORE_W = 8, DIST_NONE = 24'hFFFFFF;
  - state encoding ACCUM/CONVERT/PUBLISH;
  - the packing bit positions, so that this block and the decision comparator agree.
- One natural sub-module, ai_dist_to_score: a combinational shift-saturate-invert, reusable and testable on its own.

Test Plan:
- After rst, one frame with class2 = 24'h000100 and class5 = 24'h000000, then frame_done -> score_rdy in cycle 9; reg1 = 32'h0000FE00, reg2 = 32'h00FF0000, min = 24'h000000.
- Class0 receives 24'h000500, 24'h000300, 24'h000300, then frame_done -> reg1[31:24] = 8'hFC, min = 24'h000300.
- Saturation: class7 = 24'h00FF00 -> score 0; class6 = 24'h010000 -> score 0; class4 = 24'h00FEFF -> 8'h01.
- Empty frame: frame_done only -> reg1 = reg2 = 0, min = 24'hFFFFFF, score_rdy pulses once.
- dist_valid in cycle 3 after frame_done -> sample ignored, drop_err = 1; the next frame starts clean and drop_err stays 1 until init.
- init asserted in cycle 4 of CONVERT -> no score_rdy; reg1 = reg2 = 0, min = 24'hFFFFFF, busy = 0 in the next cycle.

Source files
------------

// File: rtl/ai_score_pack_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ai_score_pack_pkg
//  Description : Shared constants, FSM encoding and score packing layout for
//                ai_score_pack and the downstream decision comparator.
//  Revision    : 1.0 - initial release
// ============================================================================
package ai_score_pack_pkg;

    localparam int NCLASS       = 8;
    localparam int DIST_W       = 24;
    localparam int SCORE_W      = 8;
    localparam int CLS_PER_WORD = 4;

    localparam logic [23:0] DIST_NONE = 24'hFFFFFF;

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_CONVERT = 2'd1,
        ST_PUBLISH = 2'd2
    } state_e;

    // Lowest class of a word sits in the top byte, the highest in the bottom byte.
    function automatic int score_lsb(input int cls);
        return (CLS_PER_WORD - 1 - (cls % CLS_PER_WORD)) * SCORE_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ai_dist_to_score.sv
`default_nettype none
// ============================================================================
//  Module      : ai_dist_to_score
//  Description : Combinational distance-to-similarity conversion:
//                shift right, saturate to zero, invert.
//  Revision    : 1.0 - initial release
// ============================================================================
module ai_dist_to_score #(
    parameter int DIST_W  = 24,
    parameter int SHIFT   = 8,
    parameter int SCORE_W = 8
) (
    input  logic [DIST_W-1:0]  dist_i,
    output logic [SCORE_W-1:0] score_o
);

    logic [DIST_W-1:0] shifted_w;
    logic              sat_w;

    assign shifted_w = dist_i >> SHIFT;

    // Any bit above the score width means q exceeds the score range.
    assign sat_w = |shifted_w[DIST_W-1:SCORE_W];

    // For an all-ones maximum, max - q equals the bitwise inverse of q.
    assign score_o = sat_w ? '0 : ~shifted_w[SCORE_W-1:0];

endmodule
`default_nettype wire

// File: rtl/ai_score_pack.sv
`default_nettype none
// ============================================================================
//  Module      : ai_score_pack
//  Description : Tracks per-class and global minimum distances over a frame,
//                converts them to 8-bit scores and publishes two packed words.
//  Revision    : 1.0 - initial release
// ============================================================================
module ai_score_pack #(
    parameter int NCLASS = 8,
    parameter int DIST_W = 24,
    parameter int SHIFT  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic              dist_valid,
    input  logic [2:0]        dist_class,
    input  logic [DIST_W-1:0] dist_value,
    input  logic              frame_done,
    output logic              busy,
    output logic              drop_err,
    output logic [DIST_W-1:0] min,
    output logic [31:0]       reg1,
    output logic [31:0]       reg2,
    output logic              score_rdy
);

    import ai_score_pack_pkg::*;

    state_e              state_q;
    logic [2:0]          cnt_q;
    logic [DIST_W-1:0]   cls_min_q [NCLASS];
    logic [DIST_W-1:0]   gmin_q;
    logic [SCORE_W-1:0]  stage_q   [NCLASS];
    logic [SCORE_W-1:0]  stage_d   [NCLASS];
    logic [31:0]         reg1_q;
    logic [31:0]         reg2_q;
    logic [31:0]         reg1_d;
    logic [31:0]         reg2_d;
    logic [DIST_W-1:0]   min_q;
    logic                score_rdy_q;
    logic                busy_q;
    logic                drop_err_q;
    logic [SCORE_W-1:0]  conv_score;

    ai_dist_to_score #(
        .DIST_W  (DIST_W),
        .SHIFT   (SHIFT),
        .SCORE_W (SCORE_W)
    ) u_conv (
        .dist_i  (cls_min_q[cnt_q]),
        .score_o (conv_score)
    );

    // Staging view with the class under conversion already filled in, so the
    // last class can be published on the same edge it is converted.
    always_comb begin
        stage_d        = stage_q;
        stage_d[cnt_q] = conv_score;
    end

    for (genvar g = 0; g < CLS_PER_WORD; g++) begin : g_pack
        assign reg1_d[score_lsb(g) +: SCORE_W] = stage_d[g];
        assign reg2_d[score_lsb(g) +: SCORE_W] = stage_d[g + CLS_PER_WORD];
    end

    always_ff @(posedge clk) begin
        if (rst || init) begin
            state_q     <= ST_ACCUM;
            cnt_q       <= 3'd0;
            cls_min_q   <= '{default: DIST_NONE};
            gmin_q      <= DIST_NONE;
            stage_q     <= '{default: '0};
            reg1_q      <= 32'd0;
            reg2_q      <= 32'd0;
            min_q       <= DIST_NONE;
            score_rdy_q <= 1'b0;
            busy_q      <= 1'b0;
            drop_err_q  <= 1'b0;
        end else begin
            score_rdy_q <= 1'b0;

            if (busy_q && (dist_valid || frame_done)) begin
                drop_err_q <= 1'b1;
            end

            case (state_q)
                ST_ACCUM: begin
                    if (dist_valid) begin
                        if (dist_value < cls_min_q[dist_class]) begin
                            cls_min_q[dist_class] <= dist_value;
                        end
                        if (dist_value < gmin_q) begin
                            gmin_q <= dist_value;
                        end
                    end
                    if (frame_done) begin
                        state_q <= ST_CONVERT;
                        cnt_q   <= 3'd0;
                        busy_q  <= 1'b1;
                    end
                end

                ST_CONVERT: begin
                    stage_q <= stage_d;
                    cnt_q   <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_q     <= ST_PUBLISH;
                        reg1_q      <= reg1_d;
                        reg2_q      <= reg2_d;
                        min_q       <= gmin_q;
                        score_rdy_q <= 1'b1;
                    end
                end

                ST_PUBLISH: begin
                    cls_min_q <= '{default: DIST_NONE};
                    gmin_q    <= DIST_NONE;
                    cnt_q     <= 3'd0;
                    busy_q    <= 1'b0;
                    state_q   <= ST_ACCUM;
                end

                default: begin
                    state_q <= ST_ACCUM;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign drop_err  = drop_err_q;
    assign min       = min_q;
    assign reg1      = reg1_q;
    assign reg2      = reg2_q;
    assign score_rdy = score_rdy_q;

endmodule
`default_nettype wire

// File: tb/tb_ai_score_pack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ai_score_pack
//  Description : Directed self-checking bench for ai_score_pack.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ai_score_pack;

    logic        clk;
    logic        rst;
    logic        init;
    logic        dist_valid;
    logic [2:0]  dist_class;
    logic [23:0] dist_value;
    logic        frame_done;
    logic        busy;
    logic        drop_err;
    logic [23:0] min;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic        score_rdy;

    int n_checks = 0;
    int n_pass   = 0;

    ai_score_pack dut (
        .clk        (clk),
        .rst        (rst),
        .init       (init),
        .dist_valid (dist_valid),
        .dist_class (dist_class),
        .dist_value (dist_value),
        .frame_done (frame_done),
        .busy       (busy),
        .drop_err   (drop_err),
        .min        (min),
        .reg1       (reg1),
        .reg2       (reg2),
        .score_rdy  (score_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [2:0] cls, input logic [23:0] val);
        dist_valid = 1'b1;
        dist_class = cls;
        dist_value = val;
        tick();
        dist_valid = 1'b0;
    endtask

    // frame_done in cycle 0; optional sample driven during cycle drop_cyc.
    task automatic run_frame(input int drop_cyc, input logic [2:0] dcls,
                             input logic [23:0] dval, output int lat);
        int k;
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        dist_valid = 1'b0;
        k = 1;
        while (!score_rdy && k < 20) begin
            if (k == drop_cyc) begin
                dist_valid = 1'b1;
                dist_class = dcls;
                dist_value = dval;
            end
            tick();
            dist_valid = 1'b0;
            k++;
        end
        lat = k;
    endtask

    task automatic do_frame(input string tag, input int drop_cyc, input logic [2:0] dcls,
                            input logic [23:0] dval, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [23:0] em);
        int lat;
        run_frame(drop_cyc, dcls, dval, lat);
        chk({tag, " latency"}, lat, 9);
        chk({tag, " reg1"}, reg1, e1);
        chk({tag, " reg2"}, reg2, e2);
        chk({tag, " min"}, {8'd0, min}, {8'd0, em});
        chk({tag, " busy_publish"}, {31'd0, busy}, 32'd1);
        tick();
        chk({tag, " rdy_single"}, {31'd0, score_rdy}, 32'd0);
        chk({tag, " busy_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int rdy_cnt;
        rst        = 1'b1;
        init       = 1'b0;
        dist_valid = 1'b0;
        dist_class = 3'd0;
        dist_value = 24'd0;
        frame_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst reg1", reg1, 32'h0);
        chk("rst reg2", reg2, 32'h0);
        chk("rst min", {8'd0, min}, 32'h00FFFFFF);
        chk("rst rdy", {31'd0, score_rdy}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst drop", {31'd0, drop_err}, 32'd0);

        // Basic frame: class2 -> FE, class5 -> FF
        sample(3'd2, 24'h000100);
        sample(3'd5, 24'h000000);
        do_frame("basic", 0, 3'd0, 24'd0, 32'h0000FE00, 32'h00FF0000, 24'h000000);

        // Ties keep the first minimum; previous frame's minima cleared
        sample(3'd0, 24'h000500);
        sample(3'd0, 24'h000300);
        sample(3'd0, 24'h000300);
        do_frame("tie", 0, 3'd0, 24'd0, 32'hFC000000, 32'h00000000, 24'h000300);

        // Saturation and near-saturation
        sample(3'd7, 24'h00FF00);
        sample(3'd6, 24'h010000);
        sample(3'd4, 24'h00FEFF);
        do_frame("sat", 0, 3'd0, 24'd0, 32'h00000000, 32'h01000000, 24'h00FEFF);

        // Empty frame
        do_frame("empty", 0, 3'd0, 24'd0, 32'h0, 32'h0, 24'hFFFFFF);
        chk("empty drop", {31'd0, drop_err}, 32'd0);

        // Sample alongside frame_done is kept; sample in CONVERT cycle 3 dropped
        dist_valid = 1'b1;
        dist_class = 3'd1;
        dist_value = 24'h000400;
        do_frame("drop", 3, 3'd1, 24'h000000, 32'h00FB0000, 32'h0, 24'h000400);
        chk("drop sticky", {31'd0, drop_err}, 32'd1);

        // Next frame starts clean, drop_err still set
        sample(3'd1, 24'h000800);
        do_frame("post", 0, 3'd0, 24'd0, 32'h00F70000, 32'h0, 24'h000800);
        chk("post sticky", {31'd0, drop_err}, 32'd1);

        // init in the middle of CONVERT aborts the frame
        sample(3'd0, 24'h000000);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        tick();
        tick();
        tick();
        chk("abort busy_before", {31'd0, busy}, 32'd1);
        init = 1'b1;
        tick();
        init = 1'b0;
        chk("abort reg1", reg1, 32'h0);
        chk("abort reg2", reg2, 32'h0);
        chk("abort min", {8'd0, min}, 32'h00FFFFFF);
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort drop", {31'd0, drop_err}, 32'd0);
        rdy_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (score_rdy) rdy_cnt++;
            tick();
        end
        chk("abort no_rdy", rdy_cnt, 0);

        // Block works normally after the abort
        sample(3'd3, 24'h000100);
        do_frame("after", 0, 3'd0, 24'd0, 32'h000000FE, 32'h0, 24'h000100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
